rpc_cfg_sequencer: RTL and testbench

Boot-time register-bus master placed directly upstream of the RPC DRAM controller's Regbus request port in the FPGA top. After a start pulse it writes a parameterised table of configuration words into the controller, then polls a status register until the ready bits are set or a timeout expires. It reports busy, done and failure to the system so AXI traffic is held off until the controller is configured.

---
 rtl/rpc_cfg_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_rpc_cfg_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpc_cfg_sequencer.sv
// Boot-time Regbus master: writes a configuration table into the RPC DRAM
// controller, then polls a status register until ready or timeout.
module rpc_cfg_sequencer #(
  parameter int unsigned           NUM_CFG      = 8,
  parameter int unsigned           ADDR_WIDTH   = 48,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           STRB_WIDTH   = 6,
  parameter logic [ADDR_WIDTH-1:0] POLL_ADDR    = '0,
  parameter logic [DATA_WIDTH-1:0] POLL_MASK    = DATA_WIDTH'(1),
  parameter int unsigned           POLL_TIMEOUT = 1024
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [NUM_CFG*ADDR_WIDTH-1:0] cfg_addr_i,
  input  logic [NUM_CFG*DATA_WIDTH-1:0] cfg_data_i,
  output logic [ADDR_WIDTH-1:0]         reg_addr_o,
  output logic                          reg_write_o,
  output logic [DATA_WIDTH-1:0]         reg_wdata_o,
  output logic [STRB_WIDTH-1:0]         reg_wstrb_o,
  output logic                          reg_valid_o,
  input  logic                          reg_error_i,
  input  logic [DATA_WIDTH-1:0]         reg_rdata_i,
  input  logic                          reg_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          fail_o,
  output logic [6:0]                    fail_idx_o
);

  localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
  localparam int unsigned TBL_N = 1 << IDX_W;
  localparam int unsigned CNT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CFG - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_TIMEOUT);
  localparam logic [6:0]       POLL_FAIL_IDX = 7'h7F;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_POLL, S_DONE, S_FAIL} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        poll_cnt_q, poll_cnt_d;
  logic                    valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    fail_q, fail_d;
  logic [6:0]              fail_idx_q, fail_idx_d;

  logic [ADDR_WIDTH-1:0]   tbl_addr [TBL_N];
  logic [DATA_WIDTH-1:0]   tbl_data [TBL_N];

  // Unpack the flattened table; padding entries beyond NUM_CFG are never selected
  for (genvar k = 0; k < TBL_N; k++) begin : g_tbl
    if (k < NUM_CFG) begin : g_live
      assign tbl_addr[k] = cfg_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign tbl_data[k] = cfg_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign tbl_addr[k] = '0;
      assign tbl_data[k] = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      poll_cnt_q <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      poll_cnt_q <= poll_cnt_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  // Request fields hold while valid is high, so they stay stable until completion
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    poll_cnt_d = poll_cnt_q;
    valid_d    = valid_q;
    addr_d     = addr_q;
    write_d    = write_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    done_d     = done_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;

    unique case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d    = S_WRITE;
          idx_d      = '0;
          poll_cnt_d = '0;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          valid_d    = 1'b1;
          addr_d     = tbl_addr[0];
          write_d    = 1'b1;
          wdata_d    = tbl_data[0];
          wstrb_d    = '1;
        end
      end
      S_WRITE: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = tbl_addr[idx_q];
          write_d = 1'b1;
          wdata_d = tbl_data[idx_q];
          wstrb_d = '1;
        end else if (reg_ready_i) begin
          valid_d = 1'b0;
          if (reg_error_i) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            fail_idx_d = 7'(idx_q);
          end else if (idx_q == IDX_LAST) begin
            state_d = S_POLL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_POLL: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          addr_d  = POLL_ADDR;
          write_d = 1'b0;
          wdata_d = '0;
          wstrb_d = '0;
        end else if (reg_ready_i) begin
          valid_d    = 1'b0;
          poll_cnt_d = poll_cnt_q + CNT_W'(1);
          // Success is checked ahead of the timeout so the last allowed read can still pass
          if (reg_error_i) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            fail_idx_d = POLL_FAIL_IDX;
          end else if ((reg_rdata_i & POLL_MASK) == POLL_MASK) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (poll_cnt_d == CNT_MAX) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            fail_idx_d = POLL_FAIL_IDX;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d == S_WRITE) || (state_d == S_POLL);
  end

  assign reg_addr_o  = addr_q;
  assign reg_write_o = write_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;
  assign reg_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_idx_o  = fail_idx_q;

endmodule

// File: tb/tb_rpc_cfg_sequencer.sv
// Scoreboard bench for rpc_cfg_sequencer: a Regbus responder logs completed
// requests, each test compares them against its expected transaction queue.
module tb_rpc_cfg_sequencer;

  localparam int unsigned NUM_CFG = 3;
  localparam int unsigned AW = 48;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 6;
  localparam logic [AW-1:0] POLL_ADDR = 48'h100;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } txn_t;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  start_i;
  logic [NUM_CFG*AW-1:0] cfg_addr_i;
  logic [NUM_CFG*DW-1:0] cfg_data_i;
  logic [AW-1:0]         reg_addr_o;
  logic                  reg_write_o;
  logic [DW-1:0]         reg_wdata_o;
  logic [SW-1:0]         reg_wstrb_o;
  logic                  reg_valid_o;
  logic                  reg_error_i;
  logic [DW-1:0]         reg_rdata_i;
  logic                  reg_ready_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  fail_o;
  logic [6:0]            fail_idx_o;

  rpc_cfg_sequencer #(
    .NUM_CFG     (NUM_CFG),
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STRB_WIDTH  (SW),
    .POLL_ADDR   (POLL_ADDR),
    .POLL_MASK   (32'h1),
    .POLL_TIMEOUT(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_data_i (cfg_data_i),
    .reg_addr_o (reg_addr_o),
    .reg_write_o(reg_write_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_wstrb_o(reg_wstrb_o),
    .reg_valid_o(reg_valid_o),
    .reg_error_i(reg_error_i),
    .reg_rdata_i(reg_rdata_i),
    .reg_ready_i(reg_ready_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .fail_o     (fail_o),
    .fail_idx_o (fail_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int   checks = 0;
  int   failures = 0;
  txn_t exp_q[$];
  txn_t obs_q[$];
  txn_t e, o;
  int   stall_txn, stall_cyc, err_txn, ok_poll, start_at;
  int   stable_err, stall_seen;

  function automatic void push_writes(input int n);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.write = 1'b1;
      t.addr  = AW'(16 + 4 * k);
      t.wdata = DW'(10 + k);
      t.wstrb = '1;
      exp_q.push_back(t);
    end
  endfunction

  function automatic void push_reads(input int n);
    txn_t t;
    for (int k = 0; k < n; k++) begin
      t.write = 1'b0;
      t.addr  = POLL_ADDR;
      t.wdata = '0;
      t.wstrb = '0;
      exp_q.push_back(t);
    end
  endfunction

  task automatic cfg_clear();
    stall_txn = -1; stall_cyc = 0; err_txn = -1; ok_poll = 1; start_at = -1;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  // Responder: acts at each falling edge, logs each request it accepts
  task automatic bus_run(input int max_cyc);
    int   cyc = 0;
    int   txn = 0;
    int   polls = 0;
    int   waited = 0;
    bit   stalled = 1'b0;
    txn_t cur, cap;
    stable_err = 0;
    stall_seen = 0;
    cap = '0;
    while (busy_o === 1'b1 && cyc < max_cyc) begin
      cur.write = reg_write_o; cur.addr = reg_addr_o;
      cur.wdata = reg_wdata_o; cur.wstrb = reg_wstrb_o;
      if (stalled && (reg_valid_o !== 1'b1 || cur !== cap)) stable_err++;
      stalled = 1'b0;
      start_i = (cyc == start_at);
      reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
      if (reg_valid_o === 1'b1) begin
        if (txn == stall_txn && waited < stall_cyc) begin
          waited++; stall_seen++; stalled = 1'b1; cap = cur;
        end else begin
          reg_ready_i = 1'b1;
          reg_error_i = (txn == err_txn);
          if (reg_write_o === 1'b0) begin
            polls++;
            reg_rdata_i = (polls == ok_poll) ? 32'hF1 : 32'h2;
          end
          obs_q.push_back(cur);
          txn++;
        end
      end
      @(negedge clk_i);
      cyc++;
    end
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0; start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL bus_run_timeout busy=%b after %0d cycles, want busy=0", busy_o, cyc);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    checks += 4;
    if (reg_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", reg_valid_o); end
    if ({busy_o, done_o, fail_o} !== 3'b000) begin failures++; $display("FAIL reset_status got=%b want=000", {busy_o, done_o, fail_o}); end
    if (fail_idx_o !== 7'h0) begin failures++; $display("FAIL reset_fail_idx got=%h want=0", fail_idx_o); end
    if (reg_addr_o !== '0) begin failures++; $display("FAIL reset_addr got=%h want=0", reg_addr_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_basic();
    cfg_clear(); push_writes(3); push_reads(1);
    pulse_start(); bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL basic_txn got=%h want=%h", o, e); end
    end
    checks++;
    if ({done_o, busy_o, fail_o, reg_valid_o} !== 4'b1000) begin failures++; $display("FAIL basic_status got=%b want=1000", {done_o, busy_o, fail_o, reg_valid_o}); end
  endtask

  task automatic test_stall();
    cfg_clear(); stall_txn = 1; stall_cyc = 5; push_writes(3); push_reads(1);
    pulse_start(); bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL stall_txn got=%h want=%h", o, e); end
    end
    checks += 3;
    if (stable_err != 0) begin failures++; $display("FAIL stall_stable got=%0d unstable cycles want=0", stable_err); end
    if (stall_seen != 5) begin failures++; $display("FAIL stall_cycles got=%0d want=5", stall_seen); end
    if (done_o !== 1'b1) begin failures++; $display("FAIL stall_done got=%b want=1", done_o); end
  endtask

  task automatic test_write_error();
    cfg_clear(); err_txn = 2; push_writes(3);
    pulse_start(); bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL werr_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL werr_txn got=%h want=%h", o, e); end
    end
    repeat (2) @(negedge clk_i);
    checks += 2;
    if ({fail_o, done_o, reg_valid_o} !== 3'b100) begin failures++; $display("FAIL werr_status got=%b want=100", {fail_o, done_o, reg_valid_o}); end
    if (fail_idx_o !== 7'd2) begin failures++; $display("FAIL werr_fail_idx got=%h want=02", fail_idx_o); end
  endtask

  task automatic test_poll_timeout();
    cfg_clear(); ok_poll = 0; push_writes(3); push_reads(4);
    pulse_start(); bus_run(200);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ptmo_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL ptmo_txn got=%h want=%h", o, e); end
    end
    checks += 2;
    if ({fail_o, done_o} !== 2'b10) begin failures++; $display("FAIL ptmo_status got=%b want=10", {fail_o, done_o}); end
    if (fail_idx_o !== 7'h7F) begin failures++; $display("FAIL ptmo_fail_idx got=%h want=7f", fail_idx_o); end
  endtask

  task automatic test_poll_last();
    cfg_clear(); ok_poll = 4; push_writes(3); push_reads(4);
    pulse_start(); bus_run(200);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL plast_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL plast_txn got=%h want=%h", o, e); end
    end
    checks += 2;
    if ({done_o, fail_o} !== 2'b10) begin failures++; $display("FAIL plast_status got=%b want=10", {done_o, fail_o}); end
    if (fail_idx_o !== 7'h0) begin failures++; $display("FAIL plast_fail_idx got=%h want=00", fail_idx_o); end
  endtask

  task automatic test_start_in_write();
    cfg_clear(); start_at = 2; push_writes(3); push_reads(1);
    pulse_start(); bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL sinw_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL sinw_txn got=%h want=%h", o, e); end
    end
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL sinw_done got=%b want=1", done_o); end
  endtask

  task automatic test_rerun_from_done();
    cfg_clear(); push_writes(3); push_reads(1);
    pulse_start();
    checks += 2;
    if ({done_o, busy_o, reg_valid_o} !== 3'b011) begin failures++; $display("FAIL rerun_restart got=%b want=011", {done_o, busy_o, reg_valid_o}); end
    if (reg_addr_o !== 48'h10) begin failures++; $display("FAIL rerun_first_addr got=%h want=10", reg_addr_o); end
    bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rerun_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL rerun_txn got=%h want=%h", o, e); end
    end
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL rerun_done got=%b want=1", done_o); end
  endtask

  task automatic test_reset_mid();
    cfg_clear();
    pulse_start();
    @(negedge clk_i);
    checks++;
    if (reg_valid_o !== 1'b1) begin failures++; $display("FAIL rmid_pending got=%b want=1", reg_valid_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    checks += 3;
    if (reg_valid_o !== 1'b0) begin failures++; $display("FAIL rmid_valid got=%b want=0", reg_valid_o); end
    if ({busy_o, done_o, fail_o} !== 3'b000) begin failures++; $display("FAIL rmid_status got=%b want=000", {busy_o, done_o, fail_o}); end
    if (reg_addr_o !== '0 || fail_idx_o !== 7'h0) begin failures++; $display("FAIL rmid_outputs addr=%h idx=%h want 0/0", reg_addr_o, fail_idx_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    push_writes(3); push_reads(1);
    pulse_start(); bus_run(100);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rmid_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin failures++; $display("FAIL rmid_txn got=%h want=%h", o, e); end
    end
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b want=1", done_o); end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0;
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = '0;
    cfg_addr_i = {48'h18, 48'h14, 48'h10};
    cfg_data_i = {32'hC, 32'hB, 32'hA};
    cfg_clear();
    @(negedge clk_i);
    test_reset();
    test_basic();
    test_stall();
    test_write_error();
    test_poll_timeout();
    test_poll_last();
    test_start_in_write();
    test_rerun_from_done();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
